// File: rtl/spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master : SPI mode-1 (CPOL=0, CPHA=1) single-byte master, MSB first.  |
// | Option     : SPI_MASTER_CS_HOLD_EN lets hold_cs chain bytes under one CS.|
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       hold_cs,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  input  logic       spi_miso
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SETUP = 3'd1;
  localparam logic [2:0] c_SHIFT = 3'd2;
  localparam logic [2:0] c_HOLD  = 3'd3;
  localparam logic [2:0] c_GAP   = 3'd4;

  localparam logic [7:0] c_DIV_M1 = 8'(CLK_DIV - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_tx;
  logic [7:0] r_rx_sh;
  logic [7:0] r_rx;
  logic       r_busy;
  logic       r_done;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_cs_n;
  logic       r_hold;

  logic       w_div_end;
  logic       w_hold_req;

`ifdef SPI_MASTER_CS_HOLD_EN
  assign w_hold_req = hold_cs;
`else
  logic w_unused_hold;
  assign w_hold_req    = 1'b0;
  assign w_unused_hold = hold_cs;
`endif

  assign w_div_end = (r_cnt == c_DIV_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= 8'h00;
      r_bit   <= 3'd0;
      r_tx    <= 8'h00;
      r_rx_sh <= 8'h00;
      r_rx    <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_hold  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Divider restarts on every phase boundary and is parked in IDLE.
      if (r_state == c_IDLE || w_div_end) begin
        r_cnt <= 8'h00;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end

      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_tx    <= tx_data;
            r_hold  <= w_hold_req;
            r_bit   <= 3'd0;
            r_busy  <= 1'b1;
            r_cs_n  <= 1'b0;
            r_state <= c_SETUP;
          end
        end
        c_SETUP: begin
          if (w_div_end) begin
            r_sclk  <= 1'b1;
            r_mosi  <= r_tx[7];
            r_tx    <= {r_tx[6:0], 1'b0};
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          if (w_div_end) begin
            if (r_sclk) begin
              r_sclk  <= 1'b0;
              r_rx_sh <= {r_rx_sh[6:0], spi_miso};
            end else if (r_bit == 3'd7) begin
              r_state <= c_HOLD;
            end else begin
              r_sclk <= 1'b1;
              r_mosi <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
              r_bit  <= r_bit + 3'd1;
            end
          end
        end
        c_HOLD: begin
          if (w_div_end) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_rx   <= r_rx_sh;
            if (r_hold) begin
              r_state <= c_IDLE;
            end else begin
              r_cs_n  <= 1'b1;
              r_mosi  <= 1'b0;
              r_state <= c_GAP;
            end
          end
        end
        c_GAP: begin
          if (w_div_end) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_master : randomized self-checking bench with a mode-1 SPI slave.  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_spi_master;

  localparam int D = 4;
`ifdef SPI_MASTER_CS_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       hold_cs  = 1'b0;
  logic       spi_miso = 1'b0;
  logic       busy, done, spi_clk, spi_mosi, spi_cs_n;
  logic [7:0] rx_data;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .hold_cs(hold_cs),
    .busy(busy), .done(done), .rx_data(rx_data), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Mode-1 slave: drives miso on rising SCLK, captures mosi on falling SCLK.
  logic [7:0] s_sh, s_rx, s_prev, s_fixed;
  bit         s_loop = 1'b0;
  int         s_cnt  = 0;
  always @(posedge spi_clk or negedge spi_clk or posedge rst) begin
    if (rst) begin
      s_cnt    = 0;
      spi_miso = 1'b0;
    end else if (spi_clk) begin
      if (s_cnt == 0) s_sh = s_loop ? s_prev : s_fixed;
      spi_miso = s_sh[7];
      s_sh     = {s_sh[6:0], 1'b0};
      s_cnt++;
    end else begin
      s_rx = {s_rx[6:0], spi_mosi};
      if (s_cnt == 8) begin
        s_prev = s_rx;
        s_cnt  = 0;
      end
    end
  end

  // Observations of the most recent transfer
  int         o_wait, o_gap_cs_hi, o_nbits, o_nhi, o_nlo, o_phase_bad;
  int         o_done_cyc, o_done_cnt, o_cs_pre, o_cs_post, o_mosi_bad;
  bit         o_timeout, o_aborted;
  logic [7:0] o_bits, o_rx_first, o_rx_done, o_rst_rx;
  logic       o_cs_first, o_busy_done, o_cs_done;
  logic       o_rst_cs, o_rst_sclk, o_rst_mosi, o_rst_busy;

  // Reference model state
  logic [7:0] m_rx   = 8'h00;
  logic [7:0] m_last = 8'h00;
  int         exp_lat = 18 * D + 1;

  task automatic run_xfer(input logic [7:0] tx, input logic h, input bit inj, input int rst_rise);
    int   cyc, rises, last_rise, last_fall;
    logic prev_sclk;
    o_wait = 0; o_gap_cs_hi = 0; o_nbits = 0; o_nhi = 0; o_nlo = 0; o_phase_bad = 0;
    o_done_cyc = -1; o_done_cnt = 0; o_cs_pre = 0; o_cs_post = 0; o_mosi_bad = 0;
    o_timeout = 1'b0; o_aborted = 1'b0; o_bits = 8'h00;
    rises = 0; last_rise = -1; last_fall = -1;
    start = 1'b1; tx_data = tx; hold_cs = h;
    do begin
      @(negedge clk);
      o_wait++;
      if (busy !== 1'b1 && spi_cs_n !== 1'b0) o_gap_cs_hi++;
      if (spi_cs_n === 1'b1 && spi_mosi !== 1'b0) o_mosi_bad++;
    end while (busy !== 1'b1 && o_wait < 20 * D);
    start = 1'b0; hold_cs = 1'b0;
    if (busy !== 1'b1) begin
      o_timeout = 1'b1;
      return;
    end
    o_cs_first = spi_cs_n;
    o_rx_first = rx_data;
    cyc = 1;
    prev_sclk = spi_clk;
    while (cyc < 30 * D) begin
      start   = inj && (cyc == 10 || cyc == 40);
      tx_data = start ? 8'hFF : tx;
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        o_done_cnt++;
        if (o_done_cyc < 0) begin
          o_done_cyc  = cyc;
          o_rx_done   = rx_data;
          o_busy_done = busy;
          o_cs_done   = spi_cs_n;
        end
      end
      if (spi_cs_n !== 1'b0) begin
        if (o_done_cyc < 0) o_cs_pre++;
        else o_cs_post++;
      end
      if (spi_cs_n === 1'b1 && spi_mosi !== 1'b0) o_mosi_bad++;
      if (spi_clk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        if (o_nbits < 8) o_bits = {o_bits[6:0], spi_mosi};
        o_nbits++;
        if (last_fall >= 0) begin
          o_nlo++;
          if (cyc - last_fall != D) o_phase_bad++;
        end
        last_rise = cyc;
        if (rises == rst_rise) begin
          rst = 1'b1;
          #1;
          o_rst_cs = spi_cs_n; o_rst_sclk = spi_clk; o_rst_mosi = spi_mosi;
          o_rst_busy = busy; o_rst_rx = rx_data;
          o_aborted = 1'b1;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done === 1'b1) o_done_cnt++;
          end
          rst = 1'b0;
          for (int k = 0; k < 20 * D; k++) begin
            @(negedge clk);
            if (done === 1'b1) o_done_cnt++;
          end
          return;
        end
      end
      if (spi_clk === 1'b0 && prev_sclk === 1'b1) begin
        o_nhi++;
        if (cyc - last_rise != D) o_phase_bad++;
        last_fall = cyc;
      end
      prev_sclk = spi_clk;
      if (o_done_cyc >= 0 && cyc == o_done_cyc + 1) break;
    end
    start = 1'b0;
    if (o_done_cyc < 0) o_timeout = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
    n_vec++; if (spi_clk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", spi_clk); end
    n_vec++; if (spi_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    s_loop = 1'b0; s_fixed = 8'h3C;
    run_xfer(8'hA5, 1'b0, 1'b0, 0);
    n_vec++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %b want 0", o_timeout); end
    n_vec++; if (o_wait !== 1) begin n_err++; $display("FAIL basic_accept: got %0d want 1", o_wait); end
    n_vec++; if (o_cs_first !== 1'b0) begin n_err++; $display("FAIL basic_cs_first: got %b want 0", o_cs_first); end
    n_vec++; if (o_bits !== 8'hA5 || o_nbits !== 8) begin n_err++; $display("FAIL basic_mosi: got %h/%0d want a5/8", o_bits, o_nbits); end
    n_vec++; if (o_nhi !== 8 || o_nlo !== 7 || o_phase_bad !== 0) begin n_err++; $display("FAIL basic_phase: hi %0d lo %0d bad %0d want 8 7 0", o_nhi, o_nlo, o_phase_bad); end
    n_vec++; if (o_done_cyc !== exp_lat) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", o_done_cyc, exp_lat); end
    n_vec++; if (o_done_cnt !== 1) begin n_err++; $display("FAIL basic_done_pulse: got %0d want 1", o_done_cnt); end
    n_vec++; if (o_rx_done !== 8'h3C) begin n_err++; $display("FAIL basic_rx: got %h want 3c", o_rx_done); end
    n_vec++; if (o_busy_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b want 0", o_busy_done); end
    n_vec++; if (o_cs_done !== 1'b1 || o_cs_pre !== 0) begin n_err++; $display("FAIL basic_cs: done %b pre %0d want 1 0", o_cs_done, o_cs_pre); end
    n_vec++; if (o_mosi_bad !== 0) begin n_err++; $display("FAIL basic_mosi_idle: got %0d want 0", o_mosi_bad); end
    m_rx = 8'h3C; m_last = 8'hA5;
  endtask

  task automatic test_random();
    logic [7:0] tx, sv;
    s_loop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom); sv = 8'($urandom);
      s_fixed = sv;
      run_xfer(tx, 1'b0, 1'b0, 0);
      n_vec++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL rand_timeout[%0d]: got %b want 0", i, o_timeout); end
      n_vec++; if (o_bits !== tx) begin n_err++; $display("FAIL rand_mosi[%0d]: got %h want %h", i, o_bits, tx); end
      n_vec++; if (o_rx_done !== sv) begin n_err++; $display("FAIL rand_rx[%0d]: got %h want %h", i, o_rx_done, sv); end
      n_vec++; if (o_rx_first !== m_rx) begin n_err++; $display("FAIL rand_rx_hold[%0d]: got %h want %h", i, o_rx_first, m_rx); end
      n_vec++; if (o_done_cyc !== exp_lat || o_done_cnt !== 1) begin n_err++; $display("FAIL rand_done[%0d]: cyc %0d cnt %0d want %0d 1", i, o_done_cyc, o_done_cnt, exp_lat); end
      m_rx = sv; m_last = tx;
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] tx, sv;
    tx = 8'($urandom) & 8'h7E; sv = 8'($urandom);
    s_loop = 1'b0; s_fixed = sv;
    run_xfer(tx, 1'b0, 1'b1, 0);
    n_vec++; if (o_bits !== tx) begin n_err++; $display("FAIL ignore_mosi: got %h want %h", o_bits, tx); end
    n_vec++; if (o_rx_done !== sv || o_done_cyc !== exp_lat) begin n_err++; $display("FAIL ignore_rx: got %h@%0d want %h@%0d", o_rx_done, o_done_cyc, sv, exp_lat); end
    m_rx = sv; m_last = tx;
  endtask

  task automatic test_back_to_back();
    int post;
    s_loop = 1'b1;
    run_xfer(8'hA5, 1'b0, 1'b0, 0);
    n_vec++; if (o_rx_done !== m_last) begin n_err++; $display("FAIL b2b_first_rx: got %h want %h", o_rx_done, m_last); end
    post = o_cs_post;
    m_rx = m_last; m_last = 8'hA5;
    run_xfer(8'h5A, 1'b0, 1'b0, 0);
    n_vec++; if (o_rx_done !== 8'hA5) begin n_err++; $display("FAIL b2b_loop_rx: got %h want a5", o_rx_done); end
    n_vec++; if (o_bits !== 8'h5A) begin n_err++; $display("FAIL b2b_mosi: got %h want 5a", o_bits); end
    n_vec++; if (post + o_gap_cs_hi < D) begin n_err++; $display("FAIL b2b_cs_gap: got %0d want >=%0d", post + o_gap_cs_hi, D); end
    m_rx = 8'hA5; m_last = 8'h5A;
  endtask

  task automatic test_reset_mid();
    logic [7:0] tx, sv;
    s_loop = 1'b0; s_fixed = 8'h96;
    run_xfer(8'hC3, 1'b0, 1'b0, 3);
    n_vec++; if (o_aborted !== 1'b1) begin n_err++; $display("FAIL rstmid_reached: got %b want 1", o_aborted); end
    n_vec++; if ({o_rst_cs, o_rst_sclk, o_rst_mosi, o_rst_busy} !== 4'b1000) begin n_err++; $display("FAIL rstmid_outputs: got %b want 1000", {o_rst_cs, o_rst_sclk, o_rst_mosi, o_rst_busy}); end
    n_vec++; if (o_rst_rx !== 8'h00) begin n_err++; $display("FAIL rstmid_rx: got %h want 00", o_rst_rx); end
    n_vec++; if (o_done_cnt !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", o_done_cnt); end
    m_rx = 8'h00;
    tx = 8'($urandom); sv = 8'($urandom); s_fixed = sv;
    run_xfer(tx, 1'b0, 1'b0, 0);
    n_vec++; if (o_wait !== 1) begin n_err++; $display("FAIL rstmid_accept: got %0d want 1", o_wait); end
    n_vec++; if (o_bits !== tx || o_rx_done !== sv) begin n_err++; $display("FAIL rstmid_clean: got %h/%h want %h/%h", o_bits, o_rx_done, tx, sv); end
    n_vec++; if (o_done_cyc !== exp_lat) begin n_err++; $display("FAIL rstmid_latency: got %0d want %0d", o_done_cyc, exp_lat); end
    m_rx = sv; m_last = tx;
  endtask

  task automatic test_cs_hold();
    logic [7:0] tx, sv;
    logic       h, exp_cs;
    bit         gap_ok;
    int         post;
    s_loop = 1'b0;
    post = 0;
    for (int i = 0; i < 3; i++) begin
      h = (i < 2);
      tx = 8'($urandom); sv = 8'($urandom); s_fixed = sv;
      run_xfer(tx, h, 1'b0, 0);
      exp_cs = HOLD_EN ? ~h : 1'b1;
      gap_ok = HOLD_EN ? (o_gap_cs_hi == 0) : (post + o_gap_cs_hi >= D);
      if (i == 0) gap_ok = 1'b1;
      n_vec++; if (o_bits !== tx || o_rx_done !== sv) begin n_err++; $display("FAIL hold_data[%0d]: got %h/%h want %h/%h", i, o_bits, o_rx_done, tx, sv); end
      n_vec++; if (o_cs_done !== exp_cs || o_cs_pre !== 0) begin n_err++; $display("FAIL hold_cs_done[%0d]: got %b pre %0d want %b 0", i, o_cs_done, o_cs_pre, exp_cs); end
      n_vec++; if (gap_ok !== 1'b1) begin n_err++; $display("FAIL hold_cs_gap[%0d]: got %0d high cycles", i, post + o_gap_cs_hi); end
      post = o_cs_post;
      m_rx = sv; m_last = tx;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_cs_hold();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
